// File: rtl/io_map_pkg.sv
// Shared I/O address map: bit positions decoded within the CPU data address.
package io_map_pkg;

   localparam int unsigned IO_SPACE_bit  = 8;
   localparam int unsigned IO_LEDS_bit   = 2;
   localparam int unsigned IO_HEX_bit    = 3;
   localparam int unsigned IO_KEY_bit    = 4;
   localparam int unsigned IO_SW_bit     = 5;
   localparam int unsigned IO_KEYEVT_bit = 6;

   localparam int unsigned IO_DATA_W = 32;

endpackage

// File: rtl/io_input_debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter and stable (active-high) bit.
module debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic        RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise_c
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          active_c;

   // RESET_VAL is the idle pin level, so XOR with it yields an active-high bit.
   assign active_c = sync2_q ^ RESET_VAL;

   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (active_c != stable_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = active_c;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= RESET_VAL;
         sync2_q  <= RESET_VAL;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;
   assign rise_c = stable_d & ~stable_q;

endmodule

// File: rtl/io_input_debounce.sv
// Debounced KEY/SW input peripheral with sticky write-1-to-clear key-press flags.
module io_input_debounce
   import io_map_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned N_SW            = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_n,
   input  logic [N_SW-1:0]   sw,
   input  logic [31:0]       io_addr,
   input  logic              io_we,
   input  logic [31:0]       io_wdata,
   output logic [31:0]       io_rdata,
   output logic [N_KEYS-1:0] key_pressed,
   output logic [N_SW-1:0]   sw_stable,
   output logic              press_pending
);

   logic [N_KEYS-1:0] key_rise_c;
   logic [N_SW-1:0]   sw_rise_unused;
   logic [N_KEYS-1:0] press_flag_q, press_flag_d;
   logic [N_KEYS-1:0] clr_mask_c;
   logic              unused_bits;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b1)
      ) u_key (
         .clk    (clk),
         .reset  (reset),
         .raw    (key_n[i]),
         .stable (key_pressed[i]),
         .rise_c (key_rise_c[i])
      );
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b0)
      ) u_sw (
         .clk    (clk),
         .reset  (reset),
         .raw    (sw[i]),
         .stable (sw_stable[i]),
         .rise_c (sw_rise_unused[i])
      );
   end

   // A new press on the same edge as a clear keeps the flag set.
   always_comb begin
      clr_mask_c = '0;
      if (io_we && io_addr[IO_SPACE_bit] && io_addr[IO_KEYEVT_bit]) begin
         clr_mask_c = io_wdata[N_KEYS-1:0];
      end
      press_flag_d = (press_flag_q & ~clr_mask_c) | key_rise_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         press_flag_q <= '0;
      end else begin
         press_flag_q <= press_flag_d;
      end
   end

   assign press_pending = |press_flag_q;

   // Read mux, priority KEY > SW > EVT within I/O space.
   always_comb begin
      io_rdata = '0;
      if (io_addr[IO_SPACE_bit]) begin
         if (io_addr[IO_KEY_bit]) begin
            io_rdata = IO_DATA_W'(key_pressed);
         end else if (io_addr[IO_SW_bit]) begin
            io_rdata = IO_DATA_W'(sw_stable);
         end else if (io_addr[IO_KEYEVT_bit]) begin
            io_rdata = IO_DATA_W'(press_flag_q);
         end
      end
   end

   assign unused_bits = ^{io_addr, io_wdata, sw_rise_unused};

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed self-checking bench for io_input_debounce with DEBOUNCE_CYCLES=4.
module tb_io_input_debounce;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key_n;
   logic [9:0]  sw;
   logic [31:0] io_addr;
   logic        io_we;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;
   logic [3:0]  key_pressed;
   logic [9:0]  sw_stable;
   logic        press_pending;

   int n_checks = 0;
   int n_fail   = 0;

   io_input_debounce #(
      .DEBOUNCE_CYCLES (4),
      .N_KEYS          (4),
      .N_SW            (10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .key_n         (key_n),
      .sw            (sw),
      .io_addr       (io_addr),
      .io_we         (io_we),
      .io_wdata      (io_wdata),
      .io_rdata      (io_rdata),
      .key_pressed   (key_pressed),
      .sw_stable     (sw_stable),
      .press_pending (press_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      io_addr = addr;
      #1;
      check(tag, io_rdata, exp);
      io_addr = 32'h0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      io_we    = 1'b1;
      io_addr  = addr;
      io_wdata = data;
      tick(1);
      io_we    = 1'b0;
      io_addr  = 32'h0;
      io_wdata = 32'h0;
   endtask

   initial begin
      reset    = 1'b0;
      key_n    = 4'hF;
      sw       = 10'h0;
      io_addr  = 32'h0;
      io_we    = 1'b0;
      io_wdata = 32'h0;

      // Reset with all keys pressed and all switches on
      #2;
      reset = 1'b1;
      key_n = 4'h0;
      sw    = 10'h3FF;
      #1;
      check("rst_key",     32'(key_pressed), 32'h0);
      check("rst_sw",      32'(sw_stable), 32'h0);
      check("rst_pending", 32'(press_pending), 32'h0);
      rd("rst_rd_evt", 32'h140, 32'h0);
      tick(2);
      reset = 1'b0;
      tick(5);
      check("held_key_e5", 32'(key_pressed), 32'h0);
      check("held_sw_e5",  32'(sw_stable), 32'h0);
      tick(1);
      check("held_key_e6", 32'(key_pressed), 32'hF);
      check("held_sw_e6",  32'(sw_stable), 32'h3FF);
      check("held_pend",   32'(press_pending), 32'h1);
      rd("held_rd_evt", 32'h140, 32'hF);

      // Clear all flags, then release everything; release must not set flags
      wr(32'h140, 32'hF);
      rd("clr_all", 32'h140, 32'h0);
      key_n = 4'hF;
      sw    = 10'h0;
      tick(6);
      check("rel_key", 32'(key_pressed), 32'h0);
      check("rel_sw",  32'(sw_stable), 32'h0);
      rd("rel_evt", 32'h140, 32'h0);

      // Clean press of key0
      key_n = 4'b1110;
      tick(5);
      check("press_e5", 32'(key_pressed), 32'h0);
      check("press_pend_e5", 32'(press_pending), 32'h0);
      tick(1);
      check("press_e6", 32'(key_pressed), 32'h1);
      check("press_pend_e6", 32'(press_pending), 32'h1);
      rd("press_rd_evt", 32'h140, 32'h1);
      rd("press_rd_key", 32'h110, 32'h1);

      // Bounce: key1 low for 3 cycles is rejected
      key_n = 4'b1100;
      tick(3);
      key_n = 4'b1110;
      tick(8);
      check("bounce3_key", 32'(key_pressed), 32'h1);
      rd("bounce3_evt", 32'h140, 32'h1);

      // Key1 low for exactly 4 cycles is accepted at edge 6
      key_n = 4'b1100;
      tick(4);
      key_n = 4'b1110;
      tick(1);
      check("bounce4_e5", 32'(key_pressed), 32'h1);
      tick(1);
      check("bounce4_e6", 32'(key_pressed), 32'h3);
      rd("bounce4_evt", 32'h140, 32'h3);
      tick(6);
      check("bounce4_rel", 32'(key_pressed), 32'h1);

      // Build flags = 0101
      key_n = 4'hF;
      tick(6);
      wr(32'h140, 32'hF);
      key_n = 4'b1010;
      tick(6);
      check("w1c_pre_key", 32'(key_pressed), 32'h5);
      rd("w1c_pre_evt", 32'h140, 32'h5);
      wr(32'h140, 32'h4);
      rd("w1c_bit2", 32'h140, 32'h1);

      // Clear-all collides with key2 press: set wins on bit 2
      key_n = 4'b1110;
      tick(6);
      check("coll_pre_key", 32'(key_pressed), 32'h1);
      key_n = 4'b1010;
      tick(5);
      wr(32'h140, 32'hF);
      check("coll_key", 32'(key_pressed), 32'h5);
      rd("coll_evt", 32'h140, 32'h4);

      // Read mux
      sw    = 10'h2A5;
      key_n = 4'b0111;
      tick(6);
      rd("mux_sw",   32'h120, 32'h2A5);
      rd("mux_key",  32'h110, 32'h8);
      rd("mux_none", 32'h104, 32'h0);
      rd("mux_prio", 32'h170, 32'h8);
      rd("mux_evt",  32'h140, 32'hC);
      rd("mux_noio", 32'h040, 32'h0);
      wr(32'h120, 32'hFFFF_FFFF);
      check("wr_sw_ign", 32'(sw_stable), 32'h2A5);
      rd("wr_sw_evt", 32'h140, 32'hC);
      wr(32'h040, 32'hF);
      rd("wr_noio_evt", 32'h140, 32'hC);
      wr(32'h110, 32'hF);
      rd("wr_key_evt", 32'h140, 32'hC);

      // Mid-debounce reset on key2 press
      key_n = 4'b0011;
      tick(4);
      reset = 1'b1;
      #1;
      check("mid_rst_key", 32'(key_pressed), 32'h0);
      check("mid_rst_pend", 32'(press_pending), 32'h0);
      check("mid_rst_sw", 32'(sw_stable), 32'h0);
      reset = 1'b0;
      tick(5);
      check("mid_e5", 32'(key_pressed), 32'h0);
      tick(1);
      check("mid_e6_key", 32'(key_pressed), 32'hC);
      check("mid_e6_sw", 32'(sw_stable), 32'h2A5);
      rd("mid_e6_evt", 32'h140, 32'hC);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
